// File: rtl/sat_adder_pkg.sv
// -----------------------------------------------------------------------------
// sat_adder_pkg
// Shared constants and helpers for the saturating adder.
//   SAT_ADDER_WIDTH_DEFAULT      default operand/ceiling/result width
//   SAT_ADDER_CNT_WIDTH_DEFAULT  default saturation-event counter width
//   wide_opd_t / wide_sum_t      widest supported operand and its carry-extended sum
//   sat_wide_sum()               carry-preserving unsigned add of two operands
// -----------------------------------------------------------------------------
package sat_adder_pkg;

    localparam int unsigned SAT_ADDER_WIDTH_DEFAULT     = 8;
    localparam int unsigned SAT_ADDER_CNT_WIDTH_DEFAULT = 16;

    // Operands up to this many bits are supported by the shared sum helper.
    localparam int unsigned SAT_ADDER_MAX_WIDTH = 64;

    typedef logic [SAT_ADDER_MAX_WIDTH-1:0] wide_opd_t;
    typedef logic [SAT_ADDER_MAX_WIDTH:0]   wide_sum_t;

    // The extra MSB keeps the carry, so the sum never wraps.
    function automatic wide_sum_t sat_wide_sum(input wide_opd_t a, input wide_opd_t b);
        return wide_sum_t'(a) + wide_sum_t'(b);
    endfunction

endpackage

// File: rtl/sat_adder_core.sv
// -----------------------------------------------------------------------------
// sat_adder_core
// Purely combinational clamp: result = min(a + b, max).
//   a, b    in   WIDTH  unsigned operands
//   max     in   WIDTH  unsigned ceiling
//   result  out  WIDTH  clamped sum
//   sat     out  1      sum exceeded max (equality does not saturate)
// WIDTH must not exceed SAT_ADDER_MAX_WIDTH.
// -----------------------------------------------------------------------------
module sat_adder_core
    import sat_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SAT_ADDER_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] result,
    output logic             sat
);

    wide_sum_t sum;

    // The compare uses the full carry-extended sum so that a carry-out
    // always exceeds any WIDTH-bit ceiling.
    always_comb begin
        sum    = sat_wide_sum(wide_opd_t'(a), wide_opd_t'(b));
        sat    = (sum > wide_sum_t'(max));
        result = sat ? max : sum[WIDTH-1:0];
    end

endmodule

// File: rtl/sat_adder.sv
// -----------------------------------------------------------------------------
// sat_adder
// Unsigned saturating adder with a registered result, valid pipeline,
// saturation flag and a sticky saturation-event counter.
//   _m_clk        in   1          rising-edge clock
//   _m_rst_n      in   1          asynchronous active-low reset
//   _m_a, _m_b    in   WIDTH      unsigned operands
//   _m_max        in   WIDTH      saturation ceiling, sampled with the operands
//   _m_in_valid   in   1          operands/ceiling valid this cycle
//   _m_cnt_clr    in   1          synchronous counter clear (wins over increment)
//   __output      out  WIDTH      min(A+B, max)
//   _m_out_valid  out  1          __output holds a new result
//   _m_saturated  out  1          result was clamped
//   _m_sat_cnt    out  CNT_WIDTH  clamped results since reset/clear, sticks at all-ones
// Build option: define SAT_ADDER_COMB_OUT_EN for a latency-0 combinational
// result path (__output, _m_saturated, _m_out_valid); the counter stays
// registered. Default build registers the result with latency 1.
// -----------------------------------------------------------------------------
module sat_adder
    import sat_adder_pkg::*;
#(
    parameter int unsigned WIDTH     = SAT_ADDER_WIDTH_DEFAULT,
    parameter int unsigned CNT_WIDTH = SAT_ADDER_CNT_WIDTH_DEFAULT
) (
    input  logic                 _m_clk,
    input  logic                 _m_rst_n,
    input  logic [WIDTH-1:0]     _m_a,
    input  logic [WIDTH-1:0]     _m_b,
    input  logic [WIDTH-1:0]     _m_max,
    input  logic                 _m_in_valid,
    input  logic                 _m_cnt_clr,
    output logic [WIDTH-1:0]     __output,
    output logic                 _m_out_valid,
    output logic                 _m_saturated,
    output logic [CNT_WIDTH-1:0] _m_sat_cnt
);

    logic [WIDTH-1:0] core_result;
    logic             core_sat;

    sat_adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (_m_a),
        .b      (_m_b),
        .max    (_m_max),
        .result (core_result),
        .sat    (core_sat)
    );

    // Saturation-event counter: clear has priority, then a sticky increment.
    always_ff @(posedge _m_clk or negedge _m_rst_n) begin
        if (!_m_rst_n) begin
            _m_sat_cnt <= '0;
        end else if (_m_cnt_clr) begin
            _m_sat_cnt <= '0;
        end else if (_m_in_valid && core_sat && (_m_sat_cnt != '1)) begin
            _m_sat_cnt <= _m_sat_cnt + 1'b1;
        end
    end

`ifdef SAT_ADDER_COMB_OUT_EN
    always_comb begin
        __output     = core_result;
        _m_saturated = core_sat;
        _m_out_valid = _m_in_valid;
    end
`else
    // Result and flag load only on valid; otherwise they hold their last value.
    always_ff @(posedge _m_clk or negedge _m_rst_n) begin
        if (!_m_rst_n) begin
            __output     <= '0;
            _m_saturated <= 1'b0;
            _m_out_valid <= 1'b0;
        end else begin
            _m_out_valid <= _m_in_valid;
            if (_m_in_valid) begin
                __output     <= core_result;
                _m_saturated <= core_sat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sat_adder.sv
// -----------------------------------------------------------------------------
// tb_sat_adder
// Self-checking bench for sat_adder: directed vector table, counter and
// reset sequences, then randomized traffic against an arithmetic reference.
// A second instance with CNT_WIDTH=4 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_sat_adder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a, b, mx;
    logic        in_valid, cnt_clr;

    logic [7:0]  res, res4;
    logic        out_valid, out_valid4;
    logic        saturated, saturated4;
    logic [15:0] sat_cnt;
    logic [3:0]  sat_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, advanced once per rising edge from the spec rules.
    int m_out, m_sat, m_valid, m_cnt, m_cnt4;

    sat_adder #(
        .WIDTH     (8),
        .CNT_WIDTH (16)
    ) dut (
        ._m_clk       (clk),
        ._m_rst_n     (rst_n),
        ._m_a         (a),
        ._m_b         (b),
        ._m_max       (mx),
        ._m_in_valid  (in_valid),
        ._m_cnt_clr   (cnt_clr),
        .__output     (res),
        ._m_out_valid (out_valid),
        ._m_saturated (saturated),
        ._m_sat_cnt   (sat_cnt)
    );

    sat_adder #(
        .WIDTH     (8),
        .CNT_WIDTH (4)
    ) dut4 (
        ._m_clk       (clk),
        ._m_rst_n     (rst_n),
        ._m_a         (a),
        ._m_b         (b),
        ._m_max       (mx),
        ._m_in_valid  (in_valid),
        ._m_cnt_clr   (cnt_clr),
        .__output     (res4),
        ._m_out_valid (out_valid4),
        ._m_saturated (saturated4),
        ._m_sat_cnt   (sat_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic int ref_result(input int ia, input int ib, input int im);
        return (ia + ib > im) ? im : ia + ib;
    endfunction

    function automatic int ref_sat(input int ia, input int ib, input int im);
        return (ia + ib > im) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_sat = 0; m_valid = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_edge(input int ia, input int ib, input int im, input bit v, input bit c);
        int r, s;
        r = ref_result(ia, ib, im);
        s = ref_sat(ia, ib, im);
        m_valid = v;
        if (v) begin
            m_out = r;
            m_sat = s;
        end
        if (c) begin
            m_cnt  = 0;
            m_cnt4 = 0;
        end else if (v && s == 1) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
            m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
        end
    endtask

    task automatic check_all(input string tag);
`ifdef SAT_ADDER_COMB_OUT_EN
        chk({tag, "_out"},   32'(res),       32'(ref_result(int'(a), int'(b), int'(mx))));
        chk({tag, "_sat"},   32'(saturated), 32'(ref_sat(int'(a), int'(b), int'(mx))));
        chk({tag, "_valid"}, 32'(out_valid), 32'(in_valid));
`else
        chk({tag, "_out"},   32'(res),       32'(m_out));
        chk({tag, "_sat"},   32'(saturated), 32'(m_sat));
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
`endif
        chk({tag, "_cnt"},   32'(sat_cnt),   32'(m_cnt));
        chk({tag, "_cnt4"},  32'(sat_cnt4),  32'(m_cnt4));
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then compare.
    task automatic cycle(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tm,
                         input logic tv, input logic tc, input string tag);
        a = ta; b = tb_; mx = tm; in_valid = tv; cnt_clr = tc;
        @(posedge clk);
        model_edge(int'(ta), int'(tb_), int'(tm), tv, tc);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        logic [7:0] a, b, mx;
        logic       v, clr;
        logic [7:0] e_out;
        logic       e_sat, e_valid;
    } vec_t;

    vec_t vt[12];

    initial begin
        //             a     b     max   v     clr   out   sat   valid
        vt[0]  = '{8'd1,   8'd2,   8'd5,   1'b1, 1'b0, 8'd3,   1'b0, 1'b1};
        vt[1]  = '{8'd1,   8'd2,   8'd2,   1'b1, 1'b0, 8'd2,   1'b1, 1'b1};
        vt[2]  = '{8'd255, 8'd1,   8'd255, 1'b1, 1'b0, 8'd255, 1'b1, 1'b1};
        vt[3]  = '{8'd3,   8'd2,   8'd5,   1'b1, 1'b0, 8'd5,   1'b0, 1'b1};
        vt[4]  = '{8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 8'd0,   1'b0, 1'b1};
        vt[5]  = '{8'd7,   8'd0,   8'd0,   1'b1, 1'b0, 8'd0,   1'b1, 1'b1};
        vt[6]  = '{8'd9,   8'd9,   8'd3,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
        vt[7]  = '{8'd200, 8'd1,   8'd50,  1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
        vt[8]  = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
        vt[9]  = '{8'd200, 8'd100, 8'd255, 1'b1, 1'b0, 8'd255, 1'b1, 1'b1};
        vt[10] = '{8'd128, 8'd127, 8'd255, 1'b1, 1'b0, 8'd255, 1'b0, 1'b1};
        vt[11] = '{8'd100, 8'd50,  8'd200, 1'b1, 1'b0, 8'd150, 1'b0, 1'b1};

        rst_n = 1'b0; a = '0; b = '0; mx = '0; in_valid = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

`ifndef SAT_ADDER_COMB_OUT_EN
        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].a, vt[i].b, vt[i].mx, vt[i].v, vt[i].clr, "tbl");
            chk("vec_out",   32'(res),       32'(vt[i].e_out));
            chk("vec_sat",   32'(saturated), 32'(vt[i].e_sat));
            chk("vec_valid", 32'(out_valid), 32'(vt[i].e_valid));
        end
        chk("cnt_after_table", 32'(sat_cnt), 32'd4);
`else
        // Latency-0 path: result follows inputs without a clock edge.
        @(negedge clk);
        a = 8'd1; b = 8'd2; mx = 8'd5; in_valid = 1'b1;
        #1;
        chk("comb_out_3",   32'(res),       32'd3);
        chk("comb_sat_0",   32'(saturated), 32'd0);
        chk("comb_valid_1", 32'(out_valid), 32'd1);
        mx = 8'd2;
        #1;
        chk("comb_out_2",   32'(res),       32'd2);
        chk("comb_sat_1",   32'(saturated), 32'd1);
        cycle(8'd1, 8'd2, 8'd2, 1'b1, 1'b0, "comb_sync");
        chk("comb_cnt_1", 32'(sat_cnt), 32'd1);
`endif

        // Counter saturation on the 4-bit instance, then clear vs increment.
        for (int i = 0; i < 20; i++)
            cycle(8'd255, 8'd255, 8'd10, 1'b1, 1'b0, "cnt_fill");
        chk("cnt4_stuck", 32'(sat_cnt4), 32'd15);
        cycle(8'd255, 8'd255, 8'd10, 1'b1, 1'b1, "cnt_clr");
        chk("cnt_clr_wins",  32'(sat_cnt),  32'd0);
        chk("cnt4_clr_wins", 32'(sat_cnt4), 32'd0);
        cycle(8'd0, 8'd20, 8'd10, 1'b1, 1'b0, "cnt_after_clr");
        chk("cnt_restart", 32'(sat_cnt4), 32'd1);

`ifndef SAT_ADDER_COMB_OUT_EN
        // Reset mid-stream: asynchronous clear, in-flight result discarded.
        cycle(8'd10, 8'd20, 8'd100, 1'b1, 1'b0, "pre_rst");
        a = 8'd50; b = 8'd50; mx = 8'd60; in_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out",   32'(res),       32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sat",   32'(saturated), 32'd0);
        chk("async_rst_cnt",   32'(sat_cnt),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "rst_idle");
        chk("inflight_discarded", 32'(out_valid), 32'd0);
        cycle(8'd1, 8'd1, 8'd5, 1'b1, 1'b0, "rst_first");
        chk("first_after_rst", 32'(res), 32'd2);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ra, rb, rm;
            logic       rv, rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rm = 8'd0;
                1:       rm = 8'd255;
                default: rm = 8'($urandom);
            endcase
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 15) == 0);
            cycle(ra, rb, rm, rv, rc, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sat_adder.md
Name: sat_adder

Overview:
- Unsigned saturating adder: adds two WIDTH-bit operands and clamps the sum to a runtime ceiling `_m_max`.
- Used in datapaths needing bounded accumulation, e.g. credit counters and level meters.
- Output is registered by default, with a valid pipeline and a saturation indicator.
- Includes a saturating event counter for debug/performance visibility.

Parameters:
- WIDTH, 8, operand, ceiling and result width in bits.
- CNT_WIDTH, 16, width of the saturation-event counter.

Ports:
- _m_clk  input  1  rising-edge clock.
- _m_rst_n  input  1  asynchronous active-low reset.
- _m_a  input  WIDTH  operand A, unsigned.
- _m_b  input  WIDTH  operand B, unsigned.
- _m_max  input  WIDTH  saturation ceiling, unsigned.
- _m_in_valid  input  1  operands and ceiling valid this cycle.
- _m_cnt_clr  input  1  synchronous clear of the saturation counter.
- __output  output  WIDTH  result = min(A+B, max).
- _m_out_valid  output  1  __output holds a new result.
- _m_saturated  output  1  result was clamped to max.
- _m_sat_cnt  output  CNT_WIDTH  number of clamped results since reset/clear.

Behaviour:
- Arithmetic:
  - sum = A + B computed at WIDTH+1 bits; no wrap-around.
  - If sum > max, result = max and sat = 1; else result = sum[WIDTH-1:0] and sat = 0.
  - Equality sum == max gives sat = 0.
  - A carry-out with max = all-ones clamps to all-ones with sat = 1.
  - max = 0 always yields 0; sat = 1 iff A+B > 0.
  - _m_max is sampled in the same cycle as the operands, so changing it affects only results computed with the new value.
- Timing (default):
  - Latency 1 cycle, throughput 1 per cycle, no backpressure.
  - On each rising edge: `_m_out_valid` <= `_m_in_valid`.
  - When `_m_in_valid` = 1, `__output` and `_m_saturated` load the new result.
  - When `_m_in_valid` = 0, `__output` holds its last value and `_m_saturated` holds.
- Counter:
  - `_m_sat_cnt` increments on each edge where in_valid & sat.
  - It sticks at all-ones and does not wrap.
  - If `_m_cnt_clr` = 1, the counter goes to 0; clear wins over a simultaneous increment.
- Reset:
  - Asserting `_m_rst_n` low immediately forces `__output`=0, `_m_out_valid`=0, `_m_saturated`=0, `_m_sat_cnt`=0, regardless of clock.
  - After deassertion, the first valid input produces out_valid on the following edge.
  - Reset mid-stream discards the in-flight result.
- No X propagation: when valid is low, the datapath still computes from the inputs, but the registers ignore the result.

Optional Feature:
- Macro: SAT_ADDER_COMB_OUT_EN.
- Defined:
  - `__output` and `_m_saturated` are purely combinational from `_m_a`/`_m_b`/`_m_max`, with latency 0, valid within one simulation timestep of an input change.
  - `_m_out_valid` = `_m_in_valid` combinationally.
  - `_m_sat_cnt` stays registered and counts as above.
- Undefined: the registered latency-1 behaviour above.

Decomposition:
- Shared package sat_adder_pkg:
  - Default constants SAT_ADDER_WIDTH_DEFAULT=8 and SAT_ADDER_CNT_WIDTH_DEFAULT=16.
  - A function or typedef for the WIDTH+1 sum.
- Sub-module sat_adder_core: pure combinational clamp (a, b, max -> result, sat). sat_adder wraps it with the pipeline register, valid and counter.

Test Plan:
- Default build: A=1, B=2, max=5, in_valid=1 -> next edge: __output=3, saturated=0, out_valid=1, sat_cnt=0.
- Same A/B, max changed to 2 -> next edge: __output=2, saturated=1, sat_cnt=1.
- A=255, B=1, max=255 -> __output=255, saturated=1 (no wrap to 0). Then A=3, B=2, max=5 -> __output=5, saturated=0 (equality, no clamp).
- max=0, A=0, B=0 -> 0, saturated=0. Then A=7, B=0 -> 0, saturated=1. in_valid=0 for 3 cycles -> out_valid=0, __output held at 0, sat_cnt unchanged.
- Counter: with CNT_WIDTH=4, issue 20 saturating inputs -> sat_cnt sticks at 15. Assert cnt_clr together with a saturating input -> sat_cnt=0.
- Reset: drive _m_rst_n low between clock edges mid-stream -> all outputs 0 immediately. With SAT_ADDER_COMB_OUT_EN: A=1, B=2, max=5 -> __output=3 within one timestep, no clock edge needed; then max=2 -> __output=2.
